// File: rtl/vcu108_stress_test_pkg.sv
// Shared types and default timing for the stress-test PLL reset sequencer.
package vcu108_stress_test_pkg;

   typedef enum logic [1:0] {
      ST_PLL_RST   = 2'd0,
      ST_WAIT_LOCK = 2'd1,
      ST_STABLE    = 2'd2,
      ST_RUN       = 2'd3
   } state_t;

   localparam int unsigned DEF_PLL_RST_CYCLES = 16;
   localparam int unsigned DEF_LOCK_TIMEOUT   = 65536;
   localparam int unsigned DEF_STABLE_CYCLES  = 1024;
   localparam int unsigned DEF_CNT_WIDTH      = 8;

   function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/vcu108_stress_test_sync2.sv
// Generic two-flop synchronizer; both stages reset to 0.
module vcu108_stress_test_sync2 #(
   parameter int unsigned WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] s1_q;
   logic [WIDTH-1:0] s2_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q <= '0;
         s2_q <= '0;
      end else begin
         s1_q <= d_i;
         s2_q <= s1_q;
      end
   end

   assign q_o = s2_q;

endmodule

// File: rtl/vcu108_stress_test_reset_seq.sv
// Reset sequencer behind the stress-test PLL: pulses the PLL reset, waits for a
// stable lock, releases sys_rst, and counts lock timeouts and lock losses.
//
// state        | meaning
// ST_PLL_RST   | pll_rst held high for PLL_RST_CYCLES
// ST_WAIT_LOCK | waiting up to LOCK_TIMEOUT cycles for synchronized lock
// ST_STABLE    | lock must hold for STABLE_CYCLES before release
// ST_RUN       | sys_rst released, ready high; lock loss restarts the PLL
module vcu108_stress_test_reset_seq
   import vcu108_stress_test_pkg::*;
#(
   parameter int unsigned PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
   parameter int unsigned LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
   parameter int unsigned STABLE_CYCLES  = DEF_STABLE_CYCLES,
   parameter int unsigned CNT_WIDTH      = DEF_CNT_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 pll_locked,
   output logic                 pll_rst,
   output logic                 sys_rst,
   output logic                 ready,
   output logic [CNT_WIDTH-1:0] lock_loss_count,
   output logic [CNT_WIDTH-1:0] timeout_count
);

   localparam int unsigned TMR_W = $clog2(max3(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES)) + 1;
   localparam logic [TMR_W-1:0] PR_LAST = TMR_W'(PLL_RST_CYCLES - 1);
   localparam logic [TMR_W-1:0] LT_LAST = TMR_W'(LOCK_TIMEOUT - 1);
   localparam logic [TMR_W-1:0] SC_LAST = TMR_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

   state_t               state_q, state_d;
   logic [TMR_W-1:0]     timer_q, timer_d;
   logic                 pll_rst_q, sys_rst_q, ready_q;
   logic [CNT_WIDTH-1:0] ll_cnt_q, ll_cnt_d;
   logic [CNT_WIDTH-1:0] to_cnt_q, to_cnt_d;
   logic                 lk_s2;
   logic                 ll_inc, to_inc;

   vcu108_stress_test_sync2 #(.WIDTH(1)) u_lock_sync (
      .clk (clk),
      .rst (rst),
      .d_i (pll_locked),
      .q_o (lk_s2)
   );

   always_comb begin
      state_d = state_q;
      ll_inc  = 1'b0;
      to_inc  = 1'b0;
      case (state_q)
         ST_PLL_RST: begin
            if (timer_q == PR_LAST) state_d = ST_WAIT_LOCK;
         end
         ST_WAIT_LOCK: begin
            // lock takes priority over a coincident timeout
            if (lk_s2) begin
               state_d = ST_STABLE;
            end else if (timer_q == LT_LAST) begin
               state_d = ST_PLL_RST;
               to_inc  = 1'b1;
            end
         end
         ST_STABLE: begin
            if (!lk_s2)                  state_d = ST_WAIT_LOCK;
            else if (timer_q == SC_LAST) state_d = ST_RUN;
         end
         ST_RUN: begin
            if (!lk_s2) begin
               state_d = ST_PLL_RST;
               ll_inc  = 1'b1;
            end
         end
         default: state_d = ST_PLL_RST;
      endcase
   end

   // Timer restarts on every state change and idles in RUN.
   always_comb begin
      timer_d = timer_q;
      if (state_d != state_q)    timer_d = '0;
      else if (state_q != ST_RUN) timer_d = timer_q + TMR_W'(1);
   end

   always_comb begin
      ll_cnt_d = ll_cnt_q;
      to_cnt_d = to_cnt_q;
      if (ll_inc && (ll_cnt_q != CNT_MAX)) ll_cnt_d = ll_cnt_q + CNT_WIDTH'(1);
      if (to_inc && (to_cnt_q != CNT_MAX)) to_cnt_d = to_cnt_q + CNT_WIDTH'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_PLL_RST;
         timer_q   <= '0;
         pll_rst_q <= 1'b1;
         sys_rst_q <= 1'b1;
         ready_q   <= 1'b0;
         ll_cnt_q  <= '0;
         to_cnt_q  <= '0;
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         pll_rst_q <= (state_d == ST_PLL_RST);
         sys_rst_q <= (state_d != ST_RUN);
         ready_q   <= (state_d == ST_RUN);
         ll_cnt_q  <= ll_cnt_d;
         to_cnt_q  <= to_cnt_d;
      end
   end

   assign pll_rst         = pll_rst_q;
   assign sys_rst         = sys_rst_q;
   assign ready           = ready_q;
   assign lock_loss_count = ll_cnt_q;
   assign timeout_count   = to_cnt_q;

endmodule

// File: tb/tb_vcu108_stress_test_reset_seq.sv
// Directed bench for the stress-test reset sequencer at small timing values.
module tb_vcu108_stress_test_reset_seq;

   localparam int PR = 4;
   localparam int LT = 32;
   localparam int SC = 8;
   localparam int CW = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          pll_locked = 1'b0;
   logic          pll_rst, sys_rst, ready;
   logic [CW-1:0] lock_loss_count, timeout_count;

   int checks   = 0;
   int failures = 0;
   int edge_n   = 0;

   always #5 clk = ~clk;

   vcu108_stress_test_reset_seq #(
      .PLL_RST_CYCLES (PR),
      .LOCK_TIMEOUT   (LT),
      .STABLE_CYCLES  (SC),
      .CNT_WIDTH      (CW)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .pll_locked      (pll_locked),
      .pll_rst         (pll_rst),
      .sys_rst         (sys_rst),
      .ready           (ready),
      .lock_loss_count (lock_loss_count),
      .timeout_count   (timeout_count)
   );

   // n edges with pll_locked=lk; outputs after each edge must match
   typedef struct {
      int   n;
      logic lk;
      logic pr;
      logic sr;
      logic rdy;
      int   ll;
      int   to;
   } seg_t;

   seg_t segs[9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s edge=%0d actual=%0d required=%0d", name, edge_n, act, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic pr, input logic sr, input logic rdy);
      chk({tag, ".pll_rst"}, {31'd0, pll_rst}, {31'd0, pr});
      chk({tag, ".sys_rst"}, {31'd0, sys_rst}, {31'd0, sr});
      chk({tag, ".ready"},   {31'd0, ready},   {31'd0, rdy});
   endtask

   task automatic chk_cnt(input string tag, input int ll, input int to);
      chk({tag, ".lock_loss_count"}, {30'd0, lock_loss_count}, ll);
      chk({tag, ".timeout_count"},   {30'd0, timeout_count},   to);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      edge_n++;
   endtask

   task automatic run_to(input int e);
      while (edge_n < e) step();
   endtask

   task automatic do_reset(input logic lk);
      rst = 1'b1;
      pll_locked = lk;
      @(negedge clk);
      #1;
      chk_out("reset", 1'b1, 1'b1, 1'b0);
      chk_cnt("reset", 0, 0);
      @(negedge clk);
      rst = 1'b0;
      edge_n = 0;
   endtask

   initial begin
      // Bring-up (lock 10 cycles after pll_rst falls) then a lock loss in RUN.
      segs[0] = '{3,  1'b0, 1'b1, 1'b1, 1'b0, 0, 0};
      segs[1] = '{11, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0};
      segs[2] = '{10, 1'b1, 1'b0, 1'b1, 1'b0, 0, 0};
      segs[3] = '{3,  1'b1, 1'b0, 1'b0, 1'b1, 0, 0};
      segs[4] = '{2,  1'b0, 1'b0, 1'b0, 1'b1, 0, 0};
      segs[5] = '{4,  1'b0, 1'b1, 1'b1, 1'b0, 1, 0};
      segs[6] = '{1,  1'b0, 1'b0, 1'b1, 1'b0, 1, 0};
      segs[7] = '{10, 1'b1, 1'b0, 1'b1, 1'b0, 1, 0};
      segs[8] = '{2,  1'b1, 1'b0, 1'b0, 1'b1, 1, 0};

      do_reset(1'b0);
      for (int s = 0; s < 9; s++) begin
         pll_locked = segs[s].lk;
         for (int i = 0; i < segs[s].n; i++) begin
            step();
            chk_out($sformatf("seg%0d", s), segs[s].pr, segs[s].sr, segs[s].rdy);
            chk_cnt($sformatf("seg%0d", s), segs[s].ll, segs[s].to);
         end
      end

      // Lock arrives on the exact cycle the timeout would fire.
      do_reset(1'b0);
      run_to(33);
      pll_locked = 1'b1;
      run_to(35);
      chk_out("tie35", 1'b0, 1'b1, 1'b0);
      step();
      chk_out("tie36", 1'b0, 1'b1, 1'b0);
      chk_cnt("tie36", 0, 0);
      run_to(43);
      chk_out("tie43", 1'b0, 1'b1, 1'b0);
      step();
      chk_out("tie44", 1'b0, 1'b0, 1'b1);
      chk_cnt("tie44", 0, 0);

      // Lock drop seen in STABLE at timer 5 forces a fresh full window.
      do_reset(1'b0);
      run_to(4);
      pll_locked = 1'b1;
      run_to(10);
      pll_locked = 1'b0;
      run_to(12);
      pll_locked = 1'b1;
      for (int e = 13; e <= 22; e++) begin
         step();
         chk_out($sformatf("drop%0d", e), 1'b0, 1'b1, 1'b0);
      end
      step();
      chk_out("drop23", 1'b0, 1'b0, 1'b1);
      chk_cnt("drop23", 0, 0);

      // No lock: pll_rst re-pulses every PR+LT cycles, timeout count saturates.
      do_reset(1'b0);
      for (int k = 1; k <= 4; k++) begin
         run_to(36 * k - 1);
         chk_out($sformatf("to%0d_pre", k), 1'b0, 1'b1, 1'b0);
         chk_cnt($sformatf("to%0d_pre", k), 0, (k - 1 > 3) ? 3 : k - 1);
         step();
         chk_out($sformatf("to%0d_hit", k), 1'b1, 1'b1, 1'b0);
         chk_cnt($sformatf("to%0d_hit", k), 0, (k > 3) ? 3 : k);
         run_to(36 * k + 3);
         chk($sformatf("to%0d_last", k), {31'd0, pll_rst}, 32'd1);
         step();
         chk($sformatf("to%0d_end", k), {31'd0, pll_rst}, 32'd0);
      end

      // Lock, run, lose lock, relock, then async reset mid-STABLE.
      pll_locked = 1'b1;
      run_to(158);
      chk_out("ch158", 1'b0, 1'b1, 1'b0);
      step();
      chk_out("ch159", 1'b0, 1'b0, 1'b1);
      run_to(160);
      pll_locked = 1'b0;
      run_to(162);
      chk_out("ch162", 1'b0, 1'b0, 1'b1);
      chk_cnt("ch162", 0, 3);
      step();
      chk_out("ch163", 1'b1, 1'b1, 1'b0);
      chk_cnt("ch163", 1, 3);
      run_to(166);
      pll_locked = 1'b1;
      run_to(172);
      chk_out("ch172", 1'b0, 1'b1, 1'b0);
      chk_cnt("ch172", 1, 3);
      #3;
      rst = 1'b1;
      #1;
      chk_out("arst", 1'b1, 1'b1, 1'b0);
      chk_cnt("arst", 0, 0);
      @(negedge clk);
      rst = 1'b0;
      edge_n = 0;
      run_to(3);
      chk_out("rs3", 1'b1, 1'b1, 1'b0);
      step();
      chk_out("rs4", 1'b0, 1'b1, 1'b0);
      run_to(12);
      chk_out("rs12", 1'b0, 1'b1, 1'b0);
      step();
      chk_out("rs13", 1'b0, 1'b0, 1'b1);
      chk_cnt("rs13", 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/vcu108_stress_test_reset_seq.md
Name: vcu108_stress_test_reset_seq

Overview:
Reset sequencer that sits directly downstream of the stress-test PLL clock generator. It drives the PLL's reset input and consumes its asynchronous LOCKED output. It holds the stress-test logic in reset until lock has been stable for a programmable time. It re-runs the PLL reset sequence after a lock timeout or a loss of lock, and counts both events for the host.

Parameters:
PLL_RST_CYCLES, 16, number of clk cycles pll_rst is held high per attempt (>=1)
LOCK_TIMEOUT, 65536, clk cycles to wait for lock before re-resetting the PLL (>=2)
STABLE_CYCLES, 1024, consecutive synchronized-locked cycles required before releasing sys_rst (>=1)
CNT_WIDTH, 8, width of the saturating event counters

Ports:
clk  input  1  free-running board reference clock (the same clock that feeds the PLL input)
rst  input  1  asynchronous, active-high reset
pll_locked  input  1  PLL LOCKED; asynchronous to clk
pll_rst  output  1  reset request to the PLL
sys_rst  output  1  reset for downstream stress-test logic; high in every state except RUN
ready  output  1  high only in RUN
lock_loss_count  output  CNT_WIDTH  number of RUN->PLL_RST transitions caused by lock loss; saturating
timeout_count  output  CNT_WIDTH  number of WAIT_LOCK timeouts; saturating

Behaviour:
- One clock, clk. Reset is asynchronous and active-high, on port rst. All flops reset asynchronously.
- Reset values: state PLL_RST, pll_rst=1, sys_rst=1, ready=0, both counters 0, both synchronizer flops 0, timer 0.
- pll_locked passes through a 2-flop synchronizer (lk_s1 -> lk_s2). Only lk_s2 is used.
- A single timer counter serves all states. Its width is $clog2 of the largest of the three cycle parameters, plus 1. It clears on every state change.
- Outputs are registered and decoded from the next state, so each output changes on the same edge as the state.
- States and transitions:
  - PLL_RST: pll_rst=1. When timer == PLL_RST_CYCLES-1, go to WAIT_LOCK. pll_rst is therefore high for exactly PLL_RST_CYCLES cycles.
  - WAIT_LOCK: pll_rst=0.
    - lk_s2=1 -> STABLE.
    - Otherwise, when timer == LOCK_TIMEOUT-1 -> PLL_RST, and timeout_count increments.
    - If lock and timeout occur in the same cycle, lock wins and timeout_count is unchanged.
  - STABLE:
    - lk_s2=0 -> WAIT_LOCK with a fresh timeout window. No counter change.
    - When timer == STABLE_CYCLES-1 with lk_s2=1 -> RUN.
  - RUN: sys_rst=0, ready=1. lk_s2=0 -> PLL_RST, and lock_loss_count increments.
- Counters saturate at 2^CNT_WIDTH-1 and do not wrap. They clear only on rst.
- Latency:
  - pll_locked falling in RUN produces sys_rst=1 no later than the 3rd rising clk edge after the fall (2 synchronizer edges plus 1 state edge).
  - pll_locked rising in WAIT_LOCK produces sys_rst=0 exactly STABLE_CYCLES+3 edges later, provided lock stays high.
- Glitches on pll_locked shorter than one clk period may be missed. This is acceptable.
- rst asserted mid-operation returns the block to the reset values immediately. On rst deassertion the sequence restarts from PLL_RST.
- sys_rst is clk-domain. Consumers in the PLL output clock domain must re-synchronize it with their own reset synchronizer. That is outside this block.

Decomposition:
- Shared package vcu108_stress_test_pkg holds:
  - the state enum (PLL_RST, WAIT_LOCK, STABLE, RUN), 2-bit encoding
  - the default timing constants
- Sub-module vcu108_stress_test_sync2: a generic 2-flop synchronizer with async reset value 0, used for pll_locked.

Test Plan:
Bench parameters: PLL_RST_CYCLES=4, LOCK_TIMEOUT=32, STABLE_CYCLES=8, CNT_WIDTH=2.
1. Release rst, PLL model asserts locked 10 cycles after pll_rst falls -> pll_rst high exactly 4 cycles; sys_rst falls 11 edges after locked rises; ready=1; both counters 0.
2. Locked never asserts -> pll_rst re-pulses every 36 cycles (4+32); timeout_count reads 1, 2, 3, 3 (saturates).
3. Locked and timer == 31 in the same cycle -> state goes to STABLE; timeout_count unchanged.
4. In STABLE, drop locked for 2 cycles at stable count 5 -> returns to WAIT_LOCK; after relock, a full 8-cycle stability window is required; no counter change.
5. In RUN, drop locked -> sys_rst=1 and ready=0 within 3 edges; pll_rst pulses 4 cycles; lock_loss_count=1; after relock, back to RUN.
6. Assert rst asynchronously mid-STABLE (between clk edges) -> all outputs at reset values before the next edge; counters cleared; sequence restarts at PLL_RST.
